mips_dec_exec_mem: RTL and testbench

Combined decode / execute / memory-access slice of the single-issue 32-bit MIPS core. It decodes the fetched instruction and drives the register-file read ports. It computes the ALU result, zero flag, branch/jump decision and next PC, and registers them. One cycle later it drives the data-cache port and presents write-back data, address and enable to the write-back stage.

---
 rtl/mips_dec_exec_mem.sv | 139 +++++++++++++
 tb/tb_mips_dec_exec_mem.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mips_dec_exec_mem.sv
// rtl/mips_dec_exec_mem.sv - MIPS decode/execute/memory slice: combinational decode and ALU, one register stage, then the dcache port and write-back outputs
module mips_dec_exec_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [4:0]  rf_read_addr_p0,
  output logic        rf_read_en_p0,
  input  logic [31:0] rf_read_data_p0,
  output logic [4:0]  rf_read_addr_p1,
  output logic        rf_read_en_p1,
  input  logic [31:0] rf_read_data_p1,
  output logic [31:0] alu_result,
  output logic        zero_flag,
  output logic        branch_taken,
  output logic [31:0] pc_next,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_write_data,
  output logic        dcache_write_en,
  output logic        dcache_read_en,
  input  logic [31:0] dcache_read_data,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_en,
  output logic        illegal_instr
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] a, b, sext_imm, zext_imm, pc4, br_target, j_target;

  assign opcode    = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign shamt     = instr[10:6];
  assign funct     = instr[5:0];
  assign a         = rf_read_data_p0;
  assign b         = rf_read_data_p1;
  assign sext_imm  = {{16{instr[15]}}, instr[15:0]};
  assign zext_imm  = {16'h0, instr[15:0]};
  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc4[31:28], instr[25:0], 2'b00};

  assign rf_read_addr_p0 = rs;
  assign rf_read_addr_p1 = rt;

  logic [31:0] alu_d, npc_d;
  logic [4:0]  dst_d;
  logic        wr_d, ld_d, st_d, br_d, ill_d, p0_en, p1_en;

  always_comb begin
    alu_d = 32'h0;
    npc_d = pc4;
    dst_d = rd;
    wr_d  = 1'b0;
    ld_d  = 1'b0;
    st_d  = 1'b0;
    br_d  = 1'b0;
    ill_d = 1'b0;
    p0_en = 1'b1;
    p1_en = 1'b0;
    case (opcode)
      6'h00: begin
        p1_en = 1'b1;
        wr_d  = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_d = a + b;
          6'h22, 6'h23: alu_d = a - b;
          6'h24: alu_d = a & b;
          6'h25: alu_d = a | b;
          6'h26: alu_d = a ^ b;
          6'h27: alu_d = ~(a | b);
          6'h2A: alu_d = {31'h0, $signed(a) < $signed(b)};
          6'h2B: alu_d = {31'h0, a < b};
          6'h00: begin alu_d = b << shamt; p0_en = 1'b0; end
          6'h02: begin alu_d = b >> shamt; p0_en = 1'b0; end
          6'h03: begin alu_d = $unsigned($signed(b) >>> shamt); p0_en = 1'b0; end
          6'h08: begin alu_d = a; npc_d = a; br_d = 1'b1; wr_d = 1'b0; end
          default: begin ill_d = 1'b1; wr_d = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin alu_d = a + sext_imm; dst_d = rt; wr_d = 1'b1; end
      6'h0A: begin alu_d = {31'h0, $signed(a) < $signed(sext_imm)}; dst_d = rt; wr_d = 1'b1; end
      6'h0B: begin alu_d = {31'h0, a < sext_imm}; dst_d = rt; wr_d = 1'b1; end
      6'h0C: begin alu_d = a & zext_imm; dst_d = rt; wr_d = 1'b1; end
      6'h0D: begin alu_d = a | zext_imm; dst_d = rt; wr_d = 1'b1; end
      6'h0E: begin alu_d = a ^ zext_imm; dst_d = rt; wr_d = 1'b1; end
      6'h0F: begin alu_d = {instr[15:0], 16'h0}; dst_d = rt; wr_d = 1'b1; p0_en = 1'b0; end
      6'h23: begin alu_d = a + sext_imm; dst_d = rt; wr_d = 1'b1; ld_d = 1'b1; end
      6'h2B: begin alu_d = a + sext_imm; st_d = 1'b1; p1_en = 1'b1; end
      6'h04, 6'h05: begin
        alu_d = a - b;
        p1_en = 1'b1;
        // BEQ (opcode bit 0 clear) takes on equal, BNE on not-equal
        if ((alu_d == 32'h0) != opcode[0]) begin
          br_d  = 1'b1;
          npc_d = br_target;
        end
      end
      6'h02: begin npc_d = j_target; br_d = 1'b1; p0_en = 1'b0; end
      default: ill_d = 1'b1;
    endcase
  end

  assign rf_read_en_p0 = p0_en;
  assign rf_read_en_p1 = p1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result        <= 32'h0;
      zero_flag         <= 1'b0;
      branch_taken      <= 1'b0;
      pc_next           <= 32'h0;
      dcache_write_data <= 32'h0;
      dcache_write_en   <= 1'b0;
      dcache_read_en    <= 1'b0;
      wb_addr           <= 5'h0;
      wb_en             <= 1'b0;
      illegal_instr     <= 1'b0;
    end else begin
      alu_result        <= alu_d;
      zero_flag         <= (alu_d == 32'h0);
      branch_taken      <= br_d;
      pc_next           <= npc_d;
      dcache_write_data <= b;
      dcache_write_en   <= st_d;
      dcache_read_en    <= ld_d;
      wb_addr           <= dst_d;
      wb_en             <= wr_d && (dst_d != 5'h0);
      illegal_instr     <= ill_d;
    end
  end

  assign dcache_addr = alu_result;
  assign wb_data     = dcache_read_en ? dcache_read_data : alu_result;

endmodule

// File: tb/tb_mips_dec_exec_mem.sv
// tb/tb_mips_dec_exec_mem.sv - directed self-checking bench for mips_dec_exec_mem
module tb_mips_dec_exec_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, pc;
  logic [4:0]  rf_read_addr_p0, rf_read_addr_p1;
  logic        rf_read_en_p0, rf_read_en_p1;
  logic [31:0] rf_read_data_p0, rf_read_data_p1;
  logic [31:0] alu_result, pc_next, dcache_addr, dcache_write_data, dcache_read_data, wb_data;
  logic        zero_flag, branch_taken, dcache_write_en, dcache_read_en, wb_en, illegal_instr;
  logic [4:0]  wb_addr;

  int checks = 0;
  int errors = 0;

  mips_dec_exec_mem dut (
    .clk(clk), .rst(rst), .instr(instr), .pc(pc),
    .rf_read_addr_p0(rf_read_addr_p0), .rf_read_en_p0(rf_read_en_p0), .rf_read_data_p0(rf_read_data_p0),
    .rf_read_addr_p1(rf_read_addr_p1), .rf_read_en_p1(rf_read_en_p1), .rf_read_data_p1(rf_read_data_p1),
    .alu_result(alu_result), .zero_flag(zero_flag), .branch_taken(branch_taken), .pc_next(pc_next),
    .dcache_addr(dcache_addr), .dcache_write_data(dcache_write_data), .dcache_write_en(dcache_write_en),
    .dcache_read_en(dcache_read_en), .dcache_read_data(dcache_read_data),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] d0, input logic [31:0] d1);
    instr = i;
    pc = p;
    rf_read_data_p0 = d0;
    rf_read_data_p1 = d1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dcache_read_data = 32'h0;
    drive(32'h2022FFFB, 32'h100, 32'd3, 32'd9);
    step();
    check("rst_alu", alu_result, 32'h0);
    check("rst_pc_next", pc_next, 32'h0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    check("rst_rd_en", dcache_read_en, 0);
    check("rst_wr_en", dcache_write_en, 0);
    check("rst_branch", branch_taken, 0);
    check("rst_zero", zero_flag, 0);
    check("rst_illegal", illegal_instr, 0);

    rst = 1'b0;
    drive(32'h2022FFFB, 32'h100, 32'd3, 32'd9);
    check("addi_ra0", rf_read_addr_p0, 5'd1);
    check("addi_en0", rf_read_en_p0, 1);
    check("addi_en1", rf_read_en_p1, 0);
    step();
    check("addi_alu", alu_result, 32'hFFFFFFFE);
    check("addi_wb_addr", wb_addr, 5'd2);
    check("addi_wb_en", wb_en, 1);
    check("addi_wb_data", wb_data, 32'hFFFFFFFE);
    check("addi_pc_next", pc_next, 32'h104);
    check("addi_branch", branch_taken, 0);

    drive(32'h0022182A, 32'h104, 32'hFFFFFFFF, 32'd1);
    check("slt_en1", rf_read_en_p1, 1);
    step();
    check("slt_alu", alu_result, 32'd1);
    check("slt_wb_addr", wb_addr, 5'd3);
    check("slt_wb_en", wb_en, 1);

    drive(32'h0022182B, 32'h108, 32'hFFFFFFFF, 32'd1);
    step();
    check("sltu_alu", alu_result, 32'd0);
    check("sltu_zero", zero_flag, 1);

    drive(32'h8C240008, 32'h10C, 32'h1000, 32'h0);
    check("lw_en1", rf_read_en_p1, 0);
    step();
    dcache_read_data = 32'hDEADBEEF;
    #1;
    check("lw_addr", dcache_addr, 32'h1008);
    check("lw_rd_en", dcache_read_en, 1);
    check("lw_wr_en", dcache_write_en, 0);
    check("lw_wb_data", wb_data, 32'hDEADBEEF);
    check("lw_wb_addr", wb_addr, 5'd4);
    check("lw_wb_en", wb_en, 1);

    drive(32'hAC240008, 32'h110, 32'h1000, 32'h55);
    step();
    check("sw_wr_en", dcache_write_en, 1);
    check("sw_wr_data", dcache_write_data, 32'h55);
    check("sw_addr", dcache_addr, 32'h1008);
    check("sw_rd_en", dcache_read_en, 0);
    check("sw_wb_en", wb_en, 0);
    check("sw_wb_data", wb_data, 32'h1008);

    drive(32'h1022FFFE, 32'h200, 32'd7, 32'd7);
    step();
    check("beq_t_branch", branch_taken, 1);
    check("beq_t_zero", zero_flag, 1);
    check("beq_t_pc", pc_next, 32'h1FC);
    check("beq_t_wb_en", wb_en, 0);

    drive(32'h1022FFFE, 32'h200, 32'd7, 32'd8);
    step();
    check("beq_n_branch", branch_taken, 0);
    check("beq_n_zero", zero_flag, 0);
    check("beq_n_pc", pc_next, 32'h204);

    drive(32'h1422FFFE, 32'h200, 32'd7, 32'd8);
    step();
    check("bne_t_branch", branch_taken, 1);
    check("bne_t_pc", pc_next, 32'h1FC);

    drive(32'h08000040, 32'h30000000, 32'h0, 32'h0);
    check("j_en0", rf_read_en_p0, 0);
    step();
    check("j_pc", pc_next, 32'h30000100);
    check("j_branch", branch_taken, 1);
    check("j_wb_en", wb_en, 0);

    drive(32'h00A00008, 32'h500, 32'h1234, 32'h0);
    step();
    check("jr_pc", pc_next, 32'h1234);
    check("jr_branch", branch_taken, 1);
    check("jr_wb_en", wb_en, 0);

    drive(32'h00021903, 32'h504, 32'h0, 32'h80000000);
    check("sra_en0", rf_read_en_p0, 0);
    step();
    check("sra_alu", alu_result, 32'hF8000000);
    check("sra_wb_addr", wb_addr, 5'd3);

    drive(32'h3C07ABCD, 32'h508, 32'h0, 32'h0);
    step();
    check("lui_alu", alu_result, 32'hABCD0000);

    drive(32'h3422F000, 32'h50C, 32'h0000000F, 32'h0);
    step();
    check("ori_alu", alu_result, 32'h0000F00F);

    drive(32'h20200005, 32'h510, 32'd1, 32'd0);
    step();
    check("r0_alu", alu_result, 32'd6);
    check("r0_wb_en", wb_en, 0);

    drive(32'h00000000, 32'h514, 32'h0, 32'h0);
    step();
    check("nop_wb_en", wb_en, 0);
    check("nop_pc", pc_next, 32'h518);

    drive(32'hFC000000, 32'h400, 32'h0, 32'h0);
    step();
    check("ill_flag", illegal_instr, 1);
    check("ill_wb_en", wb_en, 0);
    check("ill_branch", branch_taken, 0);
    check("ill_pc", pc_next, 32'h404);
    check("ill_wr_en", dcache_write_en, 0);

    drive(32'h00000FFF, 32'h404, 32'h0, 32'h0);
    step();
    check("ill_funct", illegal_instr, 1);

    rst = 1'b1;
    drive(32'h2022FFFB, 32'h100, 32'd3, 32'd0);
    step();
    check("rst2_alu", alu_result, 32'h0);
    check("rst2_wb_en", wb_en, 0);
    check("rst2_pc", pc_next, 32'h0);
    check("rst2_illegal", illegal_instr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
